// File: rtl/mdr_mult_ctrl.sv
// ---------------------------------------------------------------------------
// mdr_mult_ctrl
//   Sequencing controller and datapath for the signed shift-add multiplier of
//   the MDR unit. Operands are taken on a start/ready handshake, converted to
//   magnitudes, multiplied with one add/shift step per cycle, re-signed and
//   presented as a 2*DW-bit product with a single-cycle done pulse.
//
//   Parameters
//     DW            operand width in bits (>= 2), matches DW_MDR of the MDR unit
//
//   Ports
//     clk           clock, all state updates on the rising edge
//     rst           synchronous reset, active-high
//     start         request, accepted only while ready=1
//     multiplicand  two's-complement operand A, captured on accept
//     multiplier    two's-complement operand B, captured on accept
//     ready         high only while idle
//     busy          high while loading, multiplying or fixing the sign
//     done          one-cycle pulse, product valid
//     product       signed A*B, held until the next operation's sign fix or reset
//
//   Build option
//     MDR_EARLY_TERM_EN  when defined, the multiply loop stops as soon as the
//                        remaining multiplier bits are all zero (and skips the
//                        loop entirely for a zero multiplier). Product values
//                        are identical in both builds; only latency changes.
// ---------------------------------------------------------------------------
module mdr_mult_ctrl #(
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   multiplicand,
    input  logic [DW-1:0]   multiplier,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DW) + 1;
    localparam int unsigned PW    = 2 * DW;

    localparam logic [DW-1:0]    ONE_DW   = DW'(1);
    localparam logic [PW-1:0]    ONE_PW   = PW'(1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DW-1:0]    a_q;
    logic [DW-1:0]    b_q;
    logic [DW-1:0]    mag_a;
    logic [DW-1:0]    mag_b;
    logic             sgn;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mc;
    logic [DW-1:0]    mp;
    logic [CNT_W-1:0] cnt;
    logic             mult_exit;

    // Magnitudes of the captured operands; -2^(DW-1) maps to 2^(DW-1),
    // which still fits in DW unsigned bits.
    always_comb begin
        mag_a = a_q[DW-1] ? (~a_q + ONE_DW) : a_q;
        mag_b = b_q[DW-1] ? (~b_q + ONE_DW) : b_q;
    end

    // Leave the loop after the step that consumes the last multiplier bit.
    always_comb begin
`ifdef MDR_EARLY_TERM_EN
        mult_exit = (cnt == LAST_CNT) || (mp[DW-1:1] == '0);
`else
        mult_exit = (cnt == LAST_CNT);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
`ifdef MDR_EARLY_TERM_EN
                if (mag_b == '0) begin
                    state_nxt = S_FIX;
                end else begin
                    state_nxt = S_MULT;
                end
`else
                state_nxt = S_MULT;
`endif
            end
            S_MULT: begin
                busy = 1'b1;
                if (mult_exit) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sgn     <= 1'b0;
            acc     <= '0;
            mc      <= '0;
            mp      <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q <= multiplicand;
                        b_q <= multiplier;
                    end
                end
                S_LOAD: begin
                    sgn <= a_q[DW-1] ^ b_q[DW-1];
                    acc <= '0;
                    mc  <= {{DW{1'b0}}, mag_a};
                    mp  <= mag_b;
                    cnt <= '0;
                end
                S_MULT: begin
                    if (mp[0]) begin
                        acc <= acc + mc;
                    end
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    cnt <= cnt + ONE_CNT;
                end
                S_FIX: begin
                    // A zero magnitude with negative sign wraps back to zero.
                    product <= sgn ? (~acc + ONE_PW) : acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_mult_ctrl.sv
module tb_mdr_mult_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 2 * DW;
    localparam int          WAIT_MAX = 4 * DW + 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] multiplicand;
    logic [DW-1:0] multiplier;
    logic          ready;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int n_tests = 0;
    int n_fail  = 0;

    mdr_mult_ctrl #(.DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    // Reference: plain signed arithmetic, truncated to the product width.
    function automatic logic [PW-1:0] model_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return PW'(sa * sb);
    endfunction

    // Negedges counted from the accept edge up to the one where done is high.
    function automatic int model_lat(input logic [DW-1:0] b);
`ifdef MDR_EARLY_TERM_EN
        longint sb;
        longint m;
        int     bits;
        sb   = longint'($signed(b));
        m    = (sb < 0) ? -sb : sb;
        bits = 0;
        while (m != 0) begin
            bits++;
            m = m >> 1;
        end
        return 3 + bits;
`else
        return DW + 3;
`endif
    endfunction

    // Issues one operation (caller is at a negedge with ready=1) and records
    // what it observes up to the done pulse. Performs no comparisons.
    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output int lat, output logic [PW-1:0] p, output bit ok,
                         output int busy_cyc, output bit rdy_seen, output bit prod_moved);
        logic [PW-1:0] prev;
        prev         = product;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = DW'($urandom);
        multiplier   = DW'($urandom);
        lat          = 1;
        ok           = 1'b0;
        busy_cyc     = 0;
        rdy_seen     = 1'b0;
        prod_moved   = 1'b0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            if (ready) rdy_seen = 1'b1;
            if (product !== prev) prod_moved = 1'b1;
            @(negedge clk);
            lat++;
        end
        p = product;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/busy/done=%b expected 100", {ready, busy, done});
        end
        n_tests++;
        if (product !== '0) begin
            n_fail++;
            $display("FAIL reset_product: got %h expected 0", product);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: got rdy/busy/done=%b expected 100", {ready, busy, done});
        end
    endtask

    task automatic test_directed();
        logic [DW-1:0] va[8]  = '{8'h03, 8'hFD, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h09, 8'h55};
        logic [DW-1:0] vb[8]  = '{8'h05, 8'h05, 8'h80, 8'h80, 8'hF9, 8'hFF, 8'h02, 8'h00};
        logic [PW-1:0] vp[8]  = '{16'h000F, 16'hFFF1, 16'h4000, 16'hC080,
                                  16'h0000, 16'h0001, 16'h0012, 16'h0000};
`ifdef MDR_EARLY_TERM_EN
        int            vl[8]  = '{6, 6, 11, 11, 6, 4, 5, 3};
`else
        int            vl[8]  = '{11, 11, 11, 11, 11, 11, 11, 11};
`endif
        int            lat;
        int            bc;
        logic [PW-1:0] p;
        bit            ok;
        bit            rs;
        bit            pm;
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], lat, p, ok, bc, rs, pm);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL dir_timeout[%0d]: no done within %0d cycles", i, WAIT_MAX);
            end
            n_tests++;
            if (p !== vp[i]) begin
                n_fail++;
                $display("FAIL dir_product[%0d]: got %h expected %h", i, p, vp[i]);
            end
            n_tests++;
            if (lat !== vl[i]) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, vl[i]);
            end
            n_tests++;
            if (bc !== vl[i] - 1 || rs) begin
                n_fail++;
                $display("FAIL dir_busy_ready[%0d]: got busy=%0d rdy_seen=%0b expected busy=%0d rdy_seen=0",
                         i, bc, rs, vl[i] - 1);
            end
            n_tests++;
            if (pm) begin
                n_fail++;
                $display("FAIL dir_product_early[%0d]: got early change expected hold", i);
            end
            @(negedge clk);
            n_tests++;
            if ({ready, busy, done} !== 3'b100 || product !== vp[i]) begin
                n_fail++;
                $display("FAIL dir_after_done[%0d]: got rdy/busy/done=%b prod=%h expected 100 prod=%h",
                         i, {ready, busy, done}, product, vp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            lat;
        int            bc;
        logic [PW-1:0] p;
        bit            ok;
        bit            rs;
        bit            pm;
        for (int i = 0; i < 40; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            if (i % 8 == 1) b = DW'($urandom_range(0, 3));
            if (i % 8 == 2) a = 8'h80;
            do_op(a, b, lat, p, ok, bc, rs, pm);
            n_tests++;
            if (!ok || p !== model_prod(a, b) || lat !== model_lat(b)) begin
                n_fail++;
                $display("FAIL rand[%0d] a=%h b=%h: got ok=%0b prod=%h lat=%0d expected prod=%h lat=%0d",
                         i, a, b, ok, p, lat, model_prod(a, b), model_lat(b));
            end
            n_tests++;
            if (pm || rs) begin
                n_fail++;
                $display("FAIL rand_hold[%0d]: got early_change=%0b rdy_seen=%0b expected 0 0", i, pm, rs);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            lat;
        int            bc;
        logic [PW-1:0] p;
        bit            ok;
        bit            rs;
        bit            pm;
        for (int i = 0; i < 5; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            do_op(a, b, lat, p, ok, bc, rs, pm);
            n_tests++;
            if (!ok || p !== model_prod(a, b)) begin
                n_fail++;
                $display("FAIL b2b_product[%0d]: got ok=%0b prod=%h expected %h", i, ok, p, model_prod(a, b));
            end
            @(negedge clk);
            n_tests++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ready);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [PW-1:0] first_p;
        int            n_done;
        a = DW'($urandom_range(1, 127));
        b = 8'h81;
        first_p = 'x;
        n_done = 0;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < WAIT_MAX; i++) begin
            if (i == 3) begin
                start        = 1'b1;
                multiplicand = DW'($urandom);
                multiplier   = DW'($urandom);
            end
            if (i == 5) start = 1'b0;
            if (done) begin
                if (n_done == 0) first_p = product;
                n_done++;
            end
            @(negedge clk);
        end
        n_tests++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d expected 1", n_done);
        end
        n_tests++;
        if (first_p !== model_prod(a, b)) begin
            n_fail++;
            $display("FAIL ignore_product: got %h expected %h", first_p, model_prod(a, b));
        end
        n_tests++;
        if (ready !== 1'b1 || product !== model_prod(a, b)) begin
            n_fail++;
            $display("FAIL ignore_idle: got rdy=%b prod=%h expected 1 %h", ready, product, model_prod(a, b));
        end
    endtask

    task automatic test_reset_mid_op();
        int            lat;
        int            bc;
        logic [PW-1:0] p;
        bit            ok;
        bit            rs;
        bit            pm;
        int            n_done;
        do_op(8'h05, 8'h07, lat, p, ok, bc, rs, pm);
        @(negedge clk);
        multiplicand = DW'($urandom_range(1, 127));
        multiplier   = 8'h81;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || product !== 16'h0023) begin
            n_fail++;
            $display("FAIL midrst_before: got busy=%b prod=%h expected 1 0023", busy, product);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({ready, busy, done} !== 3'b100 || product !== '0) begin
            n_fail++;
            $display("FAIL midrst_after: got rdy/busy/done=%b prod=%h expected 100 0000",
                     {ready, busy, done}, product);
        end
        n_done = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        n_tests++;
        if (n_done !== 0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_no_done: got dones=%0d rdy=%b expected 0 1", n_done, ready);
        end
    endtask

    task automatic test_reset_start_same_edge();
        rst          = 1'b1;
        start        = 1'b1;
        multiplicand = 8'h11;
        multiplier   = 8'h22;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        n_tests++;
        if ({ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL rst_start_edge: got rdy/busy/done=%b expected 100", {ready, busy, done});
        end
        @(negedge clk);
        n_tests++;
        if ({ready, busy, done} !== 3'b100 || product !== '0) begin
            n_fail++;
            $display("FAIL rst_start_dropped: got rdy/busy/done=%b prod=%h expected 100 0000",
                     {ready, busy, done}, product);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_op();
        test_reset_start_same_edge();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
